lp_cic_sequencer: RTL and testbench
===================================

# lp_cic_sequencer

Controller that sits between the lock-in mixer and `lp_cic_filter` and sequences the filter's circular window. It drives the filter's write address, zero-flushes the window after reset or restart, and suppresses filter outputs until the window holds only valid samples. It then forwards decimated, settled phase/quadrature results downstream.

## Interface
- `BUFFER_DEPTH`, 512: filter window length; must match `lp_cic_filter`; power of two, at least 4.
- `DATA_WIDTH`, 42: signed sample width, identical on both sides.
- `DECIM`, 1: forward every DECIM-th settled filter output; must be at least 1.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `restart`  in  1  single-cycle pulse requesting a window flush.
- `phase_in`, `quadrature_in`  in  DATA_WIDTH each  signed mixer samples.
- `valid_in`  in  1  mixer sample strobe.
- `flt_phase`, `flt_quad`  out  DATA_WIDTH each  filter inputs.
- `flt_addr`  out  $clog2(BUFFER_DEPTH)  filter write address.
- `flt_valid`  out  1  filter input strobe.
- `flt_phase_out`, `flt_quad_out`  in  DATA_WIDTH each  filter results.
- `flt_valid_out`  in  1  filter result strobe.
- `phase_out`, `quadrature_out`  out  DATA_WIDTH each  settled, decimated results.
- `valid_out`  out  1  result strobe.
- `settled`  out  1  high while results are being forwarded.
- `drop_count`  out  16  number of samples dropped since reset; saturates.

## Operation
- **FSM states:** FLUSH, FILL, RUN. Reset enters FLUSH. A `restart` in any state enters FLUSH on the next cycle.
- **FLUSH:**
  - Issues exactly BUFFER_DEPTH writes, one per cycle, with `flt_valid`=1 and data 0.
  - Moves to FILL after the BUFFER_DEPTH-th write.
  - Any `valid_in` during FLUSH is dropped and `drop_count` increments.
- **FILL:**
  - Each `valid_in` is issued to the filter.
  - After BUFFER_DEPTH issued samples, moves to RUN.
- **RUN:** each `valid_in` is issued to the filter. No exit except via `restart` or reset.
- **Simultaneous `restart` and `valid_in`:** `restart` wins; the sample is dropped and counted.
- **Address:** `flt_addr` increments by 1 after every issued write and wraps from BUFFER_DEPTH-1 to 0. It is continuous across states and is never reset by `restart`. A flush therefore covers every address exactly once.
- **Outstanding counter:** tracks filter writes issued but not yet answered.
  - +1 per `flt_valid`, -1 per `flt_valid_out`; both in the same cycle means no change.
  - Width $clog2(BUFFER_DEPTH)+1.
- **Discard counter:** width $clog2(BUFFER_DEPTH)+3.
  - On entering FLUSH it loads outstanding + 2·BUFFER_DEPTH.
  - Each `flt_valid_out` while it is nonzero decrements it; that result is discarded.
  - This discards, independent of filter latency, all in-flight stale results, all flush results, and all results from partially filled windows.
- **`settled`:** equals (state==RUN && discard==0).
- **Decimation counter:**
  - Counts kept results modulo DECIM and is cleared on entering FLUSH.
  - A result is forwarded when the counter is 0, so the first settled result is always forwarded.
- **`drop_count`:** 16-bit, saturates at 65535, cleared only by reset.

## Timing
- **Reset values:**
  - `flt_phase`, `flt_quad`, `flt_valid`, `flt_addr` = 0.
  - `phase_out`, `quadrature_out`, `valid_out` = 0; `settled` = 0; `drop_count` = 0.
  - State FLUSH; discard counter = 2·BUFFER_DEPTH; outstanding = 0.
- **First flush write:** appears in the cycle after `reset` deasserts.
- **Input path:** registered, 1-cycle latency. `valid_in` at edge n produces `flt_valid` at edge n+1, carrying the `flt_addr` value shown with it.
- **Output path:** registered, 1-cycle latency. `flt_valid_out` at edge n produces `valid_out` at edge n+1 when the result is kept.
- **Pulse widths:** `valid_out` is a single-cycle pulse. `phase_out` and `quadrature_out` hold their last value between pulses.
- **Restart mid-FLUSH:** the flush restarts and the full BUFFER_DEPTH writes are reissued. The discard counter reloads; a partial flush does not shorten the settle time.
- **Throughput:** one sample per cycle sustained in FILL and RUN, with no back-pressure.

## Structure
- **Shared lock-in package:**
  - State enum `lp_seq_state_t` {FLUSH, FILL, RUN}.
  - Constant `DROP_CNT_W` = 16.
- **Sub-module `lp_seq_counter`:** a parameterised-width up/down counter with load and saturation. It is instantiated for the outstanding and discard counters, with saturation enabled for `drop_count`.
- **Filter connection:** `lp_cic_filter` is not instantiated inside this block. The two are wired side by side in the lock-in top level.

## Test plan
All scenarios use BUFFER_DEPTH=16 and DECIM=1, with a behavioural filter model of 3-cycle latency, unless stated otherwise.
- **Reset/flush:** release reset -> 16 consecutive `flt_valid` with data 0 and addresses 0..15; `valid_out` stays 0; `settled`=0.
- **DC settle:** `valid_in` every cycle with phase 1000, quadrature -1000 ->
  - no `valid_out` for the first 32 filter results;
  - the 33rd result is forwarded with `settled`=1;
  - `flt_addr` wraps 15 -> 0 with no gap.
- **Decimation:** DECIM=4 in RUN, 40 results -> exactly 10 `valid_out` pulses, the first on the first settled result.
- **Drops:** `valid_in` held high during FLUSH -> `drop_count`=16 after the flush. Forcing 70000 drops -> `drop_count` saturates at 65535.
- **Mid-RUN restart:** `restart` pulse with 3 writes outstanding ->
  - next `valid_out` only after 3+32 further filter results;
  - the sample coinciding with `restart` is counted in `drop_count`.
- **Restart mid-FLUSH:** `restart` after 5 flush writes -> 16 fresh zero writes starting at the current `flt_addr`, with wrap.

Source files
------------

// File: rtl/lp_cic_sequencer_pkg.sv
// lp_cic_sequencer_pkg: shared lock-in types and constants for the CIC window sequencer
//   lp_seq_state_t : sequencer FSM states (FLUSH, FILL, RUN)
//   DROP_CNT_W     : width of the saturating dropped-sample counter
package lp_cic_sequencer_pkg;
   typedef enum logic [1:0] {FLUSH, FILL, RUN} lp_seq_state_t;
   localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/lp_seq_counter.sv
// lp_seq_counter: up/down counter with load priority and optional saturation at both ends
//   clk, reset   : clock, synchronous active-high reset (loads RST_VAL)
//   load_i       : load load_val_i, overriding inc_i/dec_i
//   inc_i, dec_i : count up/down; both together hold the value
//   cnt_o        : current count
module lp_seq_counter
   import lp_cic_sequencer_pkg::*;
#(
   parameter int W = DROP_CNT_W,
   parameter bit SAT = 1'b0,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;
   logic up, dn;
   always_comb begin
      up = inc_i && !dec_i && !(SAT && &cnt_q);
      dn = dec_i && !inc_i && !(SAT && cnt_q == '0);
      cnt_d = load_i ? load_val_i : up ? cnt_q + 1'b1 : dn ? cnt_q - 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= RST_VAL;
      else cnt_q <= cnt_d;
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/lp_cic_sequencer.sv
// lp_cic_sequencer: sequences the lp_cic_filter circular window and forwards settled, decimated results
//   clk, reset, restart            : clock, sync active-high reset, window flush request
//   phase_in, quadrature_in, valid_in : mixer samples
//   flt_phase, flt_quad, flt_addr, flt_valid : filter write port (zero data while flushing)
//   flt_phase_out, flt_quad_out, flt_valid_out : filter results
//   phase_out, quadrature_out, valid_out : settled, decimated results
//   settled, drop_count            : forwarding status, saturating dropped-sample count
module lp_cic_sequencer
   import lp_cic_sequencer_pkg::*;
#(
   parameter int BUFFER_DEPTH = 512,
   parameter int DATA_WIDTH = 42,
   parameter int DECIM = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           restart,
   input  logic signed [DATA_WIDTH-1:0]   phase_in,
   input  logic signed [DATA_WIDTH-1:0]   quadrature_in,
   input  logic                           valid_in,
   output logic signed [DATA_WIDTH-1:0]   flt_phase,
   output logic signed [DATA_WIDTH-1:0]   flt_quad,
   output logic [$clog2(BUFFER_DEPTH)-1:0] flt_addr,
   output logic                           flt_valid,
   input  logic signed [DATA_WIDTH-1:0]   flt_phase_out,
   input  logic signed [DATA_WIDTH-1:0]   flt_quad_out,
   input  logic                           flt_valid_out,
   output logic signed [DATA_WIDTH-1:0]   phase_out,
   output logic signed [DATA_WIDTH-1:0]   quadrature_out,
   output logic                           valid_out,
   output logic                           settled,
   output logic [DROP_CNT_W-1:0]          drop_count
);
   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
   localparam logic [AW+2:0] SETTLE = (AW+3)'(2 * BUFFER_DEPTH);
   lp_seq_state_t state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d, ptr_q, ptr_d, addr_q, addr_d;
   logic fv_q, fv_d, vo_q, vo_d;
   logic signed [DATA_WIDTH-1:0] fp_q, fp_d, fq_q, fq_d, po_q, po_d, qo_q, qo_d;
   logic [DW-1:0] dec_q, dec_d;
   logic [AW:0] outst, out_nxt;
   logic [AW+2:0] disc;
   logic flush_wr, smp_wr, issue, drop, last, keep, fwd;
   always_comb begin
      flush_wr = !restart && state_q == FLUSH;
      smp_wr = !restart && valid_in && state_q != FLUSH;
      issue = flush_wr || smp_wr;
      drop = valid_in && (restart || state_q == FLUSH);
      last = cnt_q == AW'(BUFFER_DEPTH - 1);
      // a result arriving with restart belongs to the abandoned window
      keep = settled && flt_valid_out && !restart;
      fwd = keep && dec_q == '0;
      // outstanding count after this edge; the discard reload must include the write on the wire now
      out_nxt = outst + (AW+1)'(fv_q) - (AW+1)'(flt_valid_out);
      state_d = restart ? FLUSH : (issue && last && state_q != RUN) ? (state_q == FLUSH ? FILL : RUN) : state_q;
      cnt_d = (restart || (issue && last)) ? '0 : (issue && state_q != RUN) ? cnt_q + 1'b1 : cnt_q;
      ptr_d = issue ? ptr_q + 1'b1 : ptr_q;
      addr_d = issue ? ptr_q : addr_q;
      fv_d = issue;
      fp_d = smp_wr ? phase_in : flush_wr ? '0 : fp_q;
      fq_d = smp_wr ? quadrature_in : flush_wr ? '0 : fq_q;
      dec_d = restart ? '0 : keep ? (dec_q == DW'(DECIM - 1) ? '0 : dec_q + 1'b1) : dec_q;
      vo_d = fwd;
      po_d = fwd ? flt_phase_out : po_q;
      qo_d = fwd ? flt_quad_out : qo_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FLUSH;
         cnt_q <= '0;
         ptr_q <= '0;
         addr_q <= '0;
         fv_q <= 1'b0;
         fp_q <= '0;
         fq_q <= '0;
         dec_q <= '0;
         vo_q <= 1'b0;
         po_q <= '0;
         qo_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
         addr_q <= addr_d;
         fv_q <= fv_d;
         fp_q <= fp_d;
         fq_q <= fq_d;
         dec_q <= dec_d;
         vo_q <= vo_d;
         po_q <= po_d;
         qo_q <= qo_d;
      end
   end
   lp_seq_counter #(.W(AW + 1), .SAT(1'b0), .RST_VAL('0)) u_outst (
      .clk(clk), .reset(reset), .load_i(1'b0), .load_val_i('0),
      .inc_i(fv_q), .dec_i(flt_valid_out), .cnt_o(outst)
   );
   // saturating at zero makes it decrement only while results remain to be discarded
   lp_seq_counter #(.W(AW + 3), .SAT(1'b1), .RST_VAL(SETTLE)) u_disc (
      .clk(clk), .reset(reset), .load_i(restart), .load_val_i((AW+3)'(out_nxt) + SETTLE),
      .inc_i(1'b0), .dec_i(flt_valid_out), .cnt_o(disc)
   );
   lp_seq_counter #(.W(DROP_CNT_W), .SAT(1'b1), .RST_VAL('0)) u_drop (
      .clk(clk), .reset(reset), .load_i(1'b0), .load_val_i('0),
      .inc_i(drop), .dec_i(1'b0), .cnt_o(drop_count)
   );
   assign settled = state_q == RUN && disc == '0;
   assign flt_phase = fp_q;
   assign flt_quad = fq_q;
   assign flt_addr = addr_q;
   assign flt_valid = fv_q;
   assign phase_out = po_q;
   assign quadrature_out = qo_q;
   assign valid_out = vo_q;
endmodule

// File: tb/tb_lp_cic_sequencer.sv
// tb_lp_cic_sequencer: directed bench for lp_cic_sequencer with a 3-cycle delay-line filter model
module tb_lp_cic_sequencer;
   localparam int DW = 42;
   logic clk, reset, restart, valid_in;
   logic signed [DW-1:0] phase_in, quad_in;
   logic signed [DW-1:0] flt_phase, flt_quad, fpo, fqo, phase_out, quad_out;
   logic [3:0] flt_addr;
   logic flt_valid, fvo, valid_out, settled;
   logic [15:0] drop_count;
   logic signed [DW-1:0] flt_phase4, flt_quad4, fpo4, fqo4, phase_out4, quad_out4;
   logic [3:0] flt_addr4;
   logic flt_valid4, fvo4, valid_out4, settled4;
   logic [15:0] drop_count4;
   logic [2:0] mv, mv4;
   logic signed [DW-1:0] mp [3], mq [3], mp4 [3], mq4 [3];
   int errors, checks, res_cnt, wr_cnt;

   lp_cic_sequencer #(.BUFFER_DEPTH(16), .DATA_WIDTH(DW), .DECIM(1)) dut (
      .clk(clk), .reset(reset), .restart(restart), .phase_in(phase_in), .quadrature_in(quad_in),
      .valid_in(valid_in), .flt_phase(flt_phase), .flt_quad(flt_quad), .flt_addr(flt_addr),
      .flt_valid(flt_valid), .flt_phase_out(fpo), .flt_quad_out(fqo), .flt_valid_out(fvo),
      .phase_out(phase_out), .quadrature_out(quad_out), .valid_out(valid_out),
      .settled(settled), .drop_count(drop_count)
   );
   lp_cic_sequencer #(.BUFFER_DEPTH(16), .DATA_WIDTH(DW), .DECIM(4)) dut4 (
      .clk(clk), .reset(reset), .restart(restart), .phase_in(phase_in), .quadrature_in(quad_in),
      .valid_in(valid_in), .flt_phase(flt_phase4), .flt_quad(flt_quad4), .flt_addr(flt_addr4),
      .flt_valid(flt_valid4), .flt_phase_out(fpo4), .flt_quad_out(fqo4), .flt_valid_out(fvo4),
      .phase_out(phase_out4), .quadrature_out(quad_out4), .valid_out(valid_out4),
      .settled(settled4), .drop_count(drop_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mv <= reset ? 3'b0 : {mv[1:0], flt_valid};
      mv4 <= reset ? 3'b0 : {mv4[1:0], flt_valid4};
      mp[0] <= flt_phase;
      mp[1] <= mp[0];
      mp[2] <= mp[1];
      mq[0] <= flt_quad;
      mq[1] <= mq[0];
      mq[2] <= mq[1];
      mp4[0] <= flt_phase4;
      mp4[1] <= mp4[0];
      mp4[2] <= mp4[1];
      mq4[0] <= flt_quad4;
      mq4[1] <= mq4[0];
      mq4[2] <= mq4[1];
   end
   assign fvo = mv[2];
   assign fpo = mp[2];
   assign fqo = mq[2];
   assign fvo4 = mv4[2];
   assign fpo4 = mp4[2];
   assign fqo4 = mq4[2];

   always @(posedge clk) begin
      if (reset) begin
         res_cnt <= 0;
         wr_cnt <= 0;
      end else begin
         if (fvo === 1'b1) res_cnt <= res_cnt + 1;
         if (flt_valid === 1'b1) wr_cnt <= wr_cnt + 1;
      end
   end

   task step;
      @(posedge clk);
      #1;
   endtask

   task test_reset;
      reset = 1'b1;
      restart = 1'b0;
      valid_in = 1'b0;
      phase_in = '0;
      quad_in = '0;
      repeat (3) step;
      checks++;
      if (flt_valid !== 1'b0 || flt_addr !== 4'd0 || flt_phase !== '0 || flt_quad !== '0) begin
         errors++;
         $display("FAIL reset_flt: valid=%b addr=%0d phase=%0d quad=%0d expected all 0", flt_valid, flt_addr, flt_phase, flt_quad);
      end
      checks++;
      if (valid_out !== 1'b0 || phase_out !== '0 || quad_out !== '0) begin
         errors++;
         $display("FAIL reset_out: valid_out=%b phase=%0d quad=%0d expected all 0", valid_out, phase_out, quad_out);
      end
      checks++;
      if (settled !== 1'b0) begin
         errors++;
         $display("FAIL reset_settled: got %b expected 0", settled);
      end
      checks++;
      if (drop_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_drop: got %0d expected 0", drop_count);
      end
   endtask

   task test_flush;
      reset = 1'b0;
      valid_in = 1'b1;
      phase_in = 42'sd1000;
      quad_in = -42'sd1000;
      for (int i = 0; i < 16; i++) begin
         step;
         checks++;
         if (flt_valid !== 1'b1 || flt_addr !== 4'(i) || flt_phase !== '0 || flt_quad !== '0 || valid_out !== 1'b0 || settled !== 1'b0) begin
            errors++;
            $display("FAIL flush_write[%0d]: valid=%b addr=%0d phase=%0d quad=%0d valid_out=%b settled=%b expected 1/%0d/0/0/0/0",
                     i, flt_valid, flt_addr, flt_phase, flt_quad, valid_out, settled, i);
         end
      end
      checks++;
      if (drop_count !== 16'd16) begin
         errors++;
         $display("FAIL flush_drops: got %0d expected 16", drop_count);
      end
   endtask

   task test_dc_settle;
      int n;
      bit seq_ok;
      n = 0;
      seq_ok = 1'b1;
      while (valid_out !== 1'b1 && n < 60) begin
         step;
         n++;
         if (flt_valid !== 1'b1 || flt_addr !== wr_cnt[3:0]) seq_ok = 1'b0;
      end
      checks++;
      if (valid_out !== 1'b1 || res_cnt !== 33) begin
         errors++;
         $display("FAIL first_settled: valid_out=%b after %0d results expected 1 after 33", valid_out, res_cnt);
      end
      checks++;
      if (!seq_ok) begin
         errors++;
         $display("FAIL addr_wrap: write strobe/address sequence broken, got 0 expected 1");
      end
      checks++;
      if (settled !== 1'b1) begin
         errors++;
         $display("FAIL settled_run: got %b expected 1", settled);
      end
      checks++;
      if (phase_out !== 42'sd1000 || quad_out !== -42'sd1000) begin
         errors++;
         $display("FAIL dc_value: phase=%0d quad=%0d expected 1000/-1000", phase_out, quad_out);
      end
      checks++;
      if (valid_out4 !== 1'b1) begin
         errors++;
         $display("FAIL decim_first: got %b expected 1", valid_out4);
      end
   endtask

   task test_decimation;
      int v1, v4;
      v1 = (valid_out === 1'b1) ? 1 : 0;
      v4 = (valid_out4 === 1'b1) ? 1 : 0;
      for (int i = 0; i < 39; i++) begin
         step;
         if (valid_out === 1'b1) v1++;
         if (valid_out4 === 1'b1) v4++;
      end
      checks++;
      if (v1 !== 40) begin
         errors++;
         $display("FAIL decim1_count: got %0d expected 40", v1);
      end
      checks++;
      if (v4 !== 10) begin
         errors++;
         $display("FAIL decim4_count: got %0d expected 10", v4);
      end
      checks++;
      if (phase_out4 !== 42'sd1000) begin
         errors++;
         $display("FAIL decim4_hold: got %0d expected 1000", phase_out4);
      end
   endtask

   task test_restart_run;
      int base, n;
      restart = 1'b1;
      step;
      restart = 1'b0;
      base = res_cnt;
      checks++;
      if (drop_count !== 16'd17) begin
         errors++;
         $display("FAIL restart_drop: got %0d expected 17", drop_count);
      end
      checks++;
      if (flt_valid !== 1'b0 || valid_out !== 1'b0 || settled !== 1'b0) begin
         errors++;
         $display("FAIL restart_quiet: flt_valid=%b valid_out=%b settled=%b expected 0/0/0", flt_valid, valid_out, settled);
      end
      n = 0;
      while (valid_out !== 1'b1 && n < 100) begin
         step;
         n++;
      end
      checks++;
      if (valid_out !== 1'b1 || res_cnt - base !== 36) begin
         errors++;
         $display("FAIL restart_settle: valid_out=%b after %0d results expected 1 after 36", valid_out, res_cnt - base);
      end
      checks++;
      if (drop_count !== 16'd33) begin
         errors++;
         $display("FAIL reflush_drops: got %0d expected 33", drop_count);
      end
   endtask

   task test_restart_flush;
      int base, n;
      logic [3:0] start;
      valid_in = 1'b0;
      restart = 1'b1;
      step;
      restart = 1'b0;
      checks++;
      if (flt_valid !== 1'b0) begin
         errors++;
         $display("FAIL rf_idle: got %b expected 0", flt_valid);
      end
      for (int i = 0; i < 5; i++) begin
         step;
         checks++;
         if (flt_valid !== 1'b1 || flt_addr !== wr_cnt[3:0] || flt_phase !== '0) begin
            errors++;
            $display("FAIL rf_partial[%0d]: valid=%b addr=%0d data=%0d expected 1/%0d/0", i, flt_valid, flt_addr, flt_phase, wr_cnt[3:0]);
         end
      end
      restart = 1'b1;
      step;
      restart = 1'b0;
      base = res_cnt;
      start = wr_cnt[3:0];
      checks++;
      if (flt_valid !== 1'b0) begin
         errors++;
         $display("FAIL rf_restart_idle: got %b expected 0", flt_valid);
      end
      for (int i = 0; i < 16; i++) begin
         step;
         checks++;
         if (flt_valid !== 1'b1 || flt_addr !== start + 4'(i) || flt_phase !== '0 || flt_quad !== '0) begin
            errors++;
            $display("FAIL rf_full[%0d]: valid=%b addr=%0d phase=%0d quad=%0d expected 1/%0d/0/0", i, flt_valid, flt_addr, flt_phase, flt_quad, start + 4'(i));
         end
      end
      step;
      checks++;
      if (flt_valid !== 1'b0) begin
         errors++;
         $display("FAIL rf_done: got %b expected 0", flt_valid);
      end
      valid_in = 1'b1;
      n = 0;
      while (valid_out !== 1'b1 && n < 120) begin
         step;
         n++;
      end
      checks++;
      if (valid_out !== 1'b1 || res_cnt - base !== 36) begin
         errors++;
         $display("FAIL rf_settle: valid_out=%b after %0d results expected 1 after 36", valid_out, res_cnt - base);
      end
   endtask

   task test_drop_sat;
      restart = 1'b1;
      valid_in = 1'b1;
      repeat (70000) step;
      checks++;
      if (drop_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL drop_sat: got %0d expected 65535", drop_count);
      end
      step;
      checks++;
      if (drop_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL drop_hold: got %0d expected 65535", drop_count);
      end
      restart = 1'b0;
   endtask

   task test_reset_clear;
      reset = 1'b1;
      valid_in = 1'b0;
      step;
      checks++;
      if (drop_count !== 16'd0 || flt_valid !== 1'b0 || settled !== 1'b0) begin
         errors++;
         $display("FAIL reset_clear: drop=%0d flt_valid=%b settled=%b expected 0/0/0", drop_count, flt_valid, settled);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset;
      test_flush;
      test_dc_settle;
      test_decimation;
      test_restart_run;
      test_restart_flush;
      test_drop_sat;
      test_reset_clear;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
